masked_pattern_detector: RTL and testbench

- Sequential, parametrised successor to the lab's fixed 8-input combinational decode of output X.
- Accepts a stream of WIDTH-bit input vectors through a valid/ready handshake.
- Compares each vector against a loadable pattern under a don't-care mask.
- Asserts x only after HOLD consecutive matching samples, and keeps a saturating count of detection events.

---
 rtl/pattern_det_pkg.sv | 15 +
 rtl/masked_compare.sv | 19 +
 rtl/masked_pattern_detector.sv | 142 ++++++++++++++
 tb/tb_masked_pattern_detector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared definitions for the masked pattern detector family: state
// encoding and default parameter values.
package pattern_det_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DETECTED = 2'd2
    } det_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 3;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/masked_compare.sv
// Purely combinational masked equality compare. A mask bit of 1 means the
// corresponding data bit must equal the pattern bit; 0 means don't care.
module masked_compare
    import pattern_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    output logic             match
);

    // Any compared bit that differs from the pattern breaks the match.
    always_comb begin
        match = ~|((data ^ pattern) & mask);
    end

endmodule

// File: rtl/masked_pattern_detector.sv
// Streaming masked pattern detector: asserts x once HOLD consecutive
// accepted samples match the loaded pattern, and counts detection events
// in a saturating counter.
module masked_pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             x_valid,
    output logic             x,
    output logic [CNT_W-1:0] hit_count
);

    // run_cnt only ever needs to reach HOLD, so size it for exactly that.
    localparam int               RUN_W    = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_R   = RUN_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    det_state_e       state_q,     state_d;
    logic [WIDTH-1:0] pattern_q,   pattern_d;
    logic [WIDTH-1:0] mask_q,      mask_d;
    logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
    logic             x_q,         x_d;
    logic             x_valid_q,   x_valid_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic             match;
    logic             accept;
    logic [RUN_W-1:0] run_inc;

    masked_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .data    (in_data),
        .pattern (pattern_q),
        .mask    (mask_q),
        .match   (match)
    );

    // Handshake: samples are refused until a pattern is loaded and during a load.
    always_comb begin
        in_ready = (state_q != IDLE) && !load;
        accept   = in_valid && in_ready;
        run_inc  = run_cnt_q + RUN_W'(1);
    end

    // Next-state logic for the FSM, run counter, result flag and hit counter.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        mask_d      = mask_q;
        run_cnt_d   = run_cnt_q;
        x_d         = x_q;
        x_valid_d   = 1'b0;
        hit_count_d = hit_count_q;

        if (load) begin
            pattern_d = pat_in;
            mask_d    = mask_in;
            run_cnt_d = '0;
            x_d       = 1'b0;
            state_d   = ARMED;
        end else if (accept) begin
            x_valid_d = 1'b1;
            case (state_q)
                ARMED: begin
                    if (match) begin
                        run_cnt_d = run_inc;
                        if (run_inc == HOLD_R) begin
                            state_d = DETECTED;
                            x_d     = 1'b1;
                            if (hit_count_q != CNT_MAX) begin
                                hit_count_d = hit_count_q + CNT_W'(1);
                            end
                        end else begin
                            x_d = 1'b0;
                        end
                    end else begin
                        run_cnt_d = '0;
                        x_d       = 1'b0;
                    end
                end
                DETECTED: begin
                    if (match) begin
                        x_d = 1'b1;
                    end else begin
                        run_cnt_d = '0;
                        x_d       = 1'b0;
                        state_d   = ARMED;
                    end
                end
                default: begin
                end
            endcase
        end

        // A clear overrides any detection landing in the same cycle.
        if (clear) begin
            hit_count_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            mask_q      <= '0;
            run_cnt_q   <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
            run_cnt_q   <= run_cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Registered outputs.
    always_comb begin
        x         = x_q;
        x_valid   = x_valid_q;
        hit_count = hit_count_q;
    end

endmodule

// File: tb/tb_masked_pattern_detector.sv
// Self-checking bench for masked_pattern_detector (WIDTH=8, HOLD=3, CNT_W=8).
// Expected values come from a streak-counting reference model.
module tb_masked_pattern_detector;

    localparam int WIDTH = 8;
    localparam int HOLD  = 3;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] pat_in;
    logic [WIDTH-1:0] mask_in;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             x_valid;
    logic             x;
    logic [CNT_W-1:0] hit_count;

    int vectors;
    int miscompares;

    // Reference model state
    bit               m_armed;
    logic [WIDTH-1:0] m_pat;
    logic [WIDTH-1:0] m_mask;
    int               m_streak;
    bit               m_x;
    bit               m_xv;
    int               m_hit;

    masked_pattern_detector #(
        .WIDTH (WIDTH),
        .HOLD  (HOLD),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .pat_in    (pat_in),
        .mask_in   (mask_in),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .x_valid   (x_valid),
        .x         (x),
        .hit_count (hit_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts a miscompare and reports it on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Return model to its post-reset state
    task automatic modelReset();
        m_armed  = 1'b0;
        m_pat    = '0;
        m_mask   = '0;
        m_streak = 0;
        m_x      = 1'b0;
        m_xv     = 1'b0;
        m_hit    = 0;
    endtask

    // Apply one cycle of stimulus, update the model, and check all outputs
    task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] pat,
                                 input logic [WIDTH-1:0] msk, input logic clr,
                                 input logic vld, input logic [WIDTH-1:0] data);
        bit matched;
        vectors++;
        load     = ld;
        pat_in   = pat;
        mask_in  = msk;
        clear    = clr;
        in_valid = vld;
        in_data  = data;
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (m_armed && !ld)});
        @(posedge clk);
        #1;
        if (ld) begin
            m_armed  = 1'b1;
            m_pat    = pat;
            m_mask   = msk;
            m_streak = 0;
            m_x      = 1'b0;
            m_xv     = 1'b0;
        end else if (m_armed && vld) begin
            matched = (((data ^ m_pat) & m_mask) == '0);
            m_xv = 1'b1;
            if (matched) begin
                m_streak++;
                if (m_streak == HOLD && m_hit < CNT_MAX) m_hit++;
                m_x = (m_streak >= HOLD);
            end else begin
                m_streak = 0;
                m_x      = 1'b0;
            end
        end else begin
            m_xv = 1'b0;
        end
        if (clr) m_hit = 0;
        checkOutput("x_valid", {31'd0, x_valid}, {31'd0, m_xv});
        checkOutput("x", {31'd0, x}, {31'd0, m_x});
        checkOutput("hit_count", {24'd0, hit_count}, m_hit);
    endtask

    // Directed scenarios followed by a randomized stream
    initial begin
        logic [WIDTH-1:0] rp, rm, rd;
        vectors     = 0;
        miscompares = 0;
        modelReset();
        rst_n    = 1'b0;
        load     = 1'b0;
        pat_in   = '0;
        mask_in  = '0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        checkOutput("rst_x", {31'd0, x}, 0);
        checkOutput("rst_x_valid", {31'd0, x_valid}, 0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 0);
        checkOutput("rst_hit", {24'd0, hit_count}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Samples offered with no pattern loaded are refused
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);

        // Exact pattern, three matches to detect, fourth keeps x high
        applyStimulus(1, 8'hF0, 8'hFF, 0, 1, 8'hF0);
        repeat (4) applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        checkOutput("first_detect_hit", {24'd0, hit_count}, 1);

        // Masked compare ignores the low nibble; 70 breaks the run
        applyStimulus(1, 8'hF0, 8'hF0, 0, 0, 8'h00);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF5);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hFA);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF3);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h70);

        // Broken run never detects until three in a row
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h00);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);

        // Saturation of the detection counter
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h00);
            repeat (3) applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        end
        checkOutput("hit_saturated", {24'd0, hit_count}, 32'hFF);

        // Clear coincident with a detection wins
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h00);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(0, 8'h00, 8'h00, 1, 1, 8'hF0);
        checkOutput("clear_wins", {24'd0, hit_count}, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);

        // Asynchronous reset while detected
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_x", {31'd0, x}, 0);
        checkOutput("async_rst_x_valid", {31'd0, x_valid}, 0);
        checkOutput("async_rst_in_ready", {31'd0, in_ready}, 0);
        checkOutput("async_rst_hit", {24'd0, hit_count}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);
        applyStimulus(1, 8'hF0, 8'hFF, 0, 0, 8'h00);
        repeat (3) applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0);

        // Randomized stream against the model
        for (int i = 0; i < 800; i++) begin
            rp = WIDTH'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            if ($urandom_range(0, 3) != 0)
                rd = m_pat ^ (WIDTH'($urandom) & ~m_mask);
            else
                rd = WIDTH'($urandom);
            applyStimulus(($urandom_range(0, 24) == 0), rp, rm,
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 4) != 0), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
